// File: rtl/float_mult_param.sv
// Parametrised floating-point multiplier: iterative shift-add mantissa product,
// round-to-nearest-even, flush-to-zero, special values and exception flags.
module float_mult_param #(
    parameter int EXP_W        = 8,
    parameter int MAN_W        = 23,
    parameter int BITS_PER_CYC = 1
) (
    input  logic                   clk,
    input  logic                   reset_i,
    input  logic                   start_i,
    input  logic [EXP_W+MAN_W:0]   float1_i,
    input  logic [EXP_W+MAN_W:0]   float2_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [EXP_W+MAN_W:0]   float_o,
    output logic [3:0]             flags_o
);
    localparam int M  = MAN_W + 1;
    localparam int N  = M / BITS_PER_CYC;
    localparam int EW = EXP_W + 2;
    localparam int CW = $clog2(N + 1);
    localparam logic signed [EW-1:0] BIAS_E = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] MAX_E  = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] ZERO_E = '0;
    localparam logic signed [EW-1:0] ONE_E  = EW'(1);
    localparam logic [EXP_W+MAN_W:0] QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, CLASS, MULT, NORM, ROUND, DONE} state_t;

    state_t state_q, state_d;

    logic [EXP_W+MAN_W:0]   a_q, b_q;
    logic                   sign_q;
    logic signed [EW-1:0]   e_q;
    logic [2*M-1:0]         prod_q, mcand_q;
    logic [M-1:0]           mb_q;
    logic [CW-1:0]          cnt_q;
    logic [EXP_W+MAN_W:0]   float_q;
    logic [3:0]             flags_q;

    // Operand classification on the latched operands.
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
    logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, special, sign_ab;

    assign ea      = a_q[MAN_W +: EXP_W];
    assign eb      = b_q[MAN_W +: EXP_W];
    assign ma      = a_q[MAN_W-1:0];
    assign mb      = b_q[MAN_W-1:0];
    assign a_zero  = (ea == '0);
    assign b_zero  = (eb == '0);
    assign a_inf   = (&ea) && (ma == '0);
    assign b_inf   = (&eb) && (mb == '0);
    assign a_nan   = (&ea) && (ma != '0);
    assign b_nan   = (&eb) && (mb != '0);
    assign special = a_zero | a_inf | a_nan | b_zero | b_inf | b_nan;
    assign sign_ab = a_q[EXP_W+MAN_W] ^ b_q[EXP_W+MAN_W];

    logic [EXP_W+MAN_W:0] spec_res;
    logic [3:0]           spec_flags;

    // NOTE: every variable written in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        spec_res   = {sign_ab, {(EXP_W+MAN_W){1'b0}}};
        spec_flags = 4'b0000;
        if (a_nan || b_nan) begin
            spec_res = QNAN;
        end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
            spec_res   = QNAN;
            spec_flags = 4'b1000;
        end else if (a_inf || b_inf) begin
            spec_res = {sign_ab, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end
    end

    logic [2*M-1:0] addend;
    assign addend = mcand_q * {{(2*M-BITS_PER_CYC){1'b0}}, mb_q[BITS_PER_CYC-1:0]};

    // Rounding on the normalised product: significand in the top M bits.
    logic                 guard, sticky, inexact;
    logic [M:0]           rounded;
    logic signed [EW-1:0] e_r;
    logic [EXP_W+MAN_W:0] round_res;
    logic [3:0]           round_flags;

    assign guard   = prod_q[M-1];
    assign sticky  = |prod_q[M-2:0];
    assign inexact = guard | sticky;
    assign rounded = {1'b0, prod_q[2*M-1:M]} + (M+1)'(guard & (sticky | prod_q[M]));
    assign e_r     = e_q + $signed({{(EW-1){1'b0}}, rounded[M]});

    always_comb begin
        round_res   = {sign_q, e_r[EXP_W-1:0], rounded[MAN_W-1:0]};
        round_flags = {3'b000, inexact};
        if (e_r >= MAX_E) begin
            round_res   = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            round_flags = 4'b0101;
        end else if (e_r <= ZERO_E) begin
            round_res   = {sign_q, {(EXP_W+MAN_W){1'b0}}};
            round_flags = 4'b0011;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = CLASS;
            CLASS:   state_d = special ? DONE : MULT;
            MULT:    if (cnt_q == CW'(N - 1)) state_d = NORM;
            NORM:    state_d = ROUND;
            ROUND:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // NOTE: only results are reset; operand and datapath registers are always loaded before use.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            float_q <= '0;
            flags_q <= '0;
        end else begin
            case (state_q)
                CLASS: if (special) begin
                    float_q <= spec_res;
                    flags_q <= spec_flags;
                end
                ROUND: begin
                    float_q <= round_res;
                    flags_q <= round_flags;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        case (state_q)
            IDLE: if (start_i) begin
                a_q <= float1_i;
                b_q <= float2_i;
            end
            CLASS: begin
                sign_q  <= sign_ab;
                e_q     <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_E;
                prod_q  <= '0;
                cnt_q   <= '0;
                mcand_q <= {{M{1'b0}}, 1'b1, ma};
                mb_q    <= {1'b1, mb};
            end
            MULT: begin
                prod_q  <= prod_q + addend;
                mcand_q <= mcand_q << BITS_PER_CYC;
                mb_q    <= mb_q >> BITS_PER_CYC;
                cnt_q   <= cnt_q + 1'b1;
            end
            NORM: begin
                if (prod_q[2*M-1]) e_q    <= e_q + ONE_E;
                else               prod_q <= prod_q << 1;
            end
            default: ;
        endcase
    end

    assign busy_o  = (state_q != IDLE);
    assign done_o  = (state_q == DONE);
    assign float_o = float_q;
    assign flags_o = flags_q;
endmodule

// File: tb/tb_float_mult_param.sv
// Directed-vector bench for float_mult_param at the fp32 default configuration.
module tb_float_mult_param;
    logic        clk = 1'b0;
    logic        reset_i, start_i;
    logic [31:0] float1_i, float2_i, float_o;
    logic        busy_o, done_o;
    logic [3:0]  flags_o;

    int n_checks = 0;
    int n_fails  = 0;

    float_mult_param dut (
        .clk(clk), .reset_i(reset_i), .start_i(start_i),
        .float1_i(float1_i), .float2_i(float2_i),
        .busy_o(busy_o), .done_o(done_o), .float_o(float_o), .flags_o(flags_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] a, b, res;
        logic [3:0]  flags;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Applies one operation from an IDLE cycle, returns result, latency in edges and busy count.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic [3:0] flg,
                          output int lat, output int busy_cnt);
        int cyc;
        @(negedge clk);
        float1_i = a; float2_i = b; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        cyc = 0; busy_cnt = 0;
        while (!done_o && cyc < 200) begin
            if (busy_o) busy_cnt++;
            @(posedge clk); #1;
            cyc++;
        end
        if (!done_o) check("done_timeout", 32'd0, 32'd1);
        lat = cyc + 1;
        res = float_o;
        flg = flags_o;
        @(posedge clk); #1;
        check("done_pulse_width", {31'd0, done_o}, 32'd0);
        check("idle_after_done",  {31'd0, busy_o}, 32'd0);
        check("result_held",      float_o, res);
    endtask

    initial begin
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat, bc, dones;

        vecs[0]  = '{"3x2",        32'h40400000, 32'h40000000, 32'h40C00000, 4'b0000, 28};
        vecs[1]  = '{"1.5xm1.5",   32'h3FC00000, 32'hBFC00000, 32'hC0100000, 4'b0000, 28};
        vecs[2]  = '{"rne_tie",    32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001, 28};
        vecs[3]  = '{"sticky",     32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, 28};
        vecs[4]  = '{"inf_x_zero", 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000, 2};
        vecs[5]  = '{"negzero",    32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000, 2};
        vecs[6]  = '{"overflow",   32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101, 28};
        vecs[7]  = '{"underflow",  32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011, 28};
        vecs[8]  = '{"nan_in",     32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b0000, 2};
        vecs[9]  = '{"inf_x_neg",  32'h7F800000, 32'hC0000000, 32'hFF800000, 4'b0000, 2};
        vecs[10] = '{"round_carry",32'h3FFFFFFF, 32'h3F800001, 32'h40000000, 4'b0001, 28};
        vecs[11] = '{"subnormal",  32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000, 2};
        vecs[12] = '{"one_x_one",  32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, 28};
        vecs[13] = '{"zero_x_ninf",32'h00000000, 32'hFF800000, 32'h7FC00000, 4'b1000, 2};

        reset_i = 1'b1; start_i = 1'b0; float1_i = '0; float2_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",  {31'd0, busy_o}, 32'd0);
        check("reset_done",  {31'd0, done_o}, 32'd0);
        check("reset_float", float_o, 32'd0);
        check("reset_flags", {28'd0, flags_o}, 32'd0);
        @(negedge clk);
        reset_i = 1'b0;

        // Back-to-back operations straight from the table.
        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].a, vecs[i].b, res, flg, lat, bc);
            check({vecs[i].name, "_result"},  res, vecs[i].res);
            check({vecs[i].name, "_flags"},   {28'd0, flg}, {28'd0, vecs[i].flags});
            check({vecs[i].name, "_latency"}, lat, vecs[i].lat);
        end

        run_op(32'h3FC00000, 32'hBFC00000, res, flg, lat, bc);
        check("busy_cycles_normal", bc, 27);

        // Reset during MULT discards the operation.
        @(negedge clk);
        float1_i = 32'h40400000; float2_i = 32'h40000000; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (5) @(negedge clk);
        reset_i = 1'b1;
        @(posedge clk); #1;
        check("midreset_busy",  {31'd0, busy_o}, 32'd0);
        check("midreset_done",  {31'd0, done_o}, 32'd0);
        check("midreset_float", float_o, 32'd0);
        check("midreset_flags", {28'd0, flags_o}, 32'd0);
        @(negedge clk);
        reset_i = 1'b0;
        dones = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done_o) dones++;
        end
        check("midreset_no_done", dones, 0);

        // start_i toggled while busy with other operands is ignored.
        @(negedge clk);
        float1_i = 32'h40400000; float2_i = 32'h40000000; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        float1_i = 32'h7F800000; float2_i = 32'h00000000;
        dones = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            start_i = (c < 20) ? c[0] : 1'b0;
            if (done_o) begin
                dones++;
                check("busy_start_result", float_o, 32'h40C00000);
                check("busy_start_flags", {28'd0, flags_o}, 32'd0);
            end
        end
        check("busy_start_single_done", dones, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fails);
        $finish;
    end
endmodule
